// File: rtl/tcb_peri_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tcb_peri_uart_rx
// Brief    : UART receive deserializer. Oversamples the serial line with a
//            programmable bit period and sample point, assembles LSB-first
//            frames (start, UART_DW data, stop) and delivers each word over
//            a valid/ready stream. Framing errors and overruns are reported
//            as single-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tcb_peri_uart_rx #(
    parameter int unsigned UART_RW = 8,
    parameter int unsigned UART_DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    input  logic [UART_RW-1:0] cfg_bdr,
    input  logic [UART_RW-1:0] cfg_smp,
    output logic               str_vld,
    input  logic               str_rdy,
    output logic [UART_DW-1:0] str_dat,
    output logic               err_frm,
    output logic               err_ovf,
    output logic               busy
);

    // Bit index width; a frame needs at least two data bits for the shifter.
    localparam int unsigned   IW       = (UART_DW > 1) ? $clog2(UART_DW) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic                 rxd_m, rxd_s;
    logic [UART_RW-1:0]   cnt, cnt_n, cnt_inc, smp_e;
    logic [IW-1:0]        idx, idx_n;
    logic [UART_DW-1:0]   shr, shr_n;
    logic                 arm, arm_n;
    logic                 cnt_last, cnt_smp;
    logic                 done, frm;

    // Two-flop synchronizer; idle level of the line is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // A sample point beyond the bit period is clamped to the last cycle.
    assign smp_e    = (cfg_smp > cfg_bdr) ? cfg_bdr : cfg_smp;
    // ">=" instead of "==" keeps the counter bounded if cfg_bdr shrinks mid-frame.
    assign cnt_last = (cnt >= cfg_bdr);
    assign cnt_smp  = (cnt == smp_e);
    assign cnt_inc  = cnt_last ? '0 : cnt + UART_RW'(1);

    // FSM state, bit counter, bit index, shift register and re-arm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shr   <= '0;
            arm   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shr   <= shr_n;
            arm   <= arm_n;
        end
    end

    // Next-state logic; also flags word completion and framing errors.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        idx_n   = idx;
        shr_n   = shr;
        arm_n   = arm;
        done    = 1'b0;
        frm     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rxd_s && arm) begin
                    // The edge-detect cycle is count 0 of the start bit, so
                    // the start state continues from count 1.
                    if (cfg_bdr == '0) begin
                        state_n = ST_DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = ST_START;
                        cnt_n   = UART_RW'(1);
                    end
                end else if (rxd_s) begin
                    // Line seen high: a following falling edge is a real start.
                    arm_n = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_smp && rxd_s) begin
                    // Start bit did not hold until the sample point: glitch.
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt_last) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (cnt_smp) begin
                    shr_n = {rxd_s, shr[UART_DW-1:1]};
                end
                if (cnt_last) begin
                    if (idx == IDX_LAST) begin
                        state_n = ST_STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            ST_STOP: begin
                // Leave at the sample point so the next start edge is caught early.
                if (cnt_smp) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    if (rxd_s) begin
                        done = 1'b1;
                    end else begin
                        // Held break: do not restart until the line goes high.
                        frm   = 1'b1;
                        arm_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output stream register with overrun detection and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            str_vld <= 1'b0;
            str_dat <= '0;
            err_frm <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            err_frm <= frm;
            err_ovf <= 1'b0;
            if (done) begin
                if (!str_vld || str_rdy) begin
                    str_vld <= 1'b1;
                    str_dat <= shr;
                end else begin
                    err_ovf <= 1'b1;
                end
            end else if (str_rdy) begin
                str_vld <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tcb_peri_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcb_peri_uart_rx
// Brief    : Self-checking bench for tcb_peri_uart_rx. Serial frames are
//            driven bit by bit; received words, error pulses and latencies are
//            compared with values derived from the frame timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcb_peri_uart_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rxd;
    logic [7:0]    cfg_bdr;
    logic [7:0]    cfg_smp;
    logic          str_vld;
    logic          str_rdy;
    logic [DW-1:0] str_dat;
    logic          err_frm;
    logic          err_ovf;
    logic          busy;

    tcb_peri_uart_rx #(.UART_RW(8), .UART_DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .cfg_bdr  (cfg_bdr),
        .cfg_smp  (cfg_smp),
        .str_vld  (str_vld),
        .str_rdy  (str_rdy),
        .str_dat  (str_dat),
        .err_frm  (err_frm),
        .err_ovf  (err_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_err = 0;

    // Observed traffic, sampled on the falling edge.
    logic [DW-1:0] got_q[$];
    int   vld_cyc = 0, frm_n = 0, ovf_n = 0;
    int   t_brise = 0, t_bfall = 0, t_vrise = 0;
    logic busy_q = 1'b0, vld_q = 1'b0;

    always @(negedge clk) begin
        if (str_vld && str_rdy) got_q.push_back(str_dat);
        if (str_vld) vld_cyc++;
        if (err_frm) frm_n++;
        if (err_ovf) ovf_n++;
        if (busy && !busy_q) t_brise = cyc;
        if (!busy && busy_q) t_bfall = cyc;
        if (str_vld && !vld_q) t_vrise = cyc;
        busy_q = busy;
        vld_q  = str_vld;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles from the first busy cycle to the first str_vld cycle:
    // (data bits + start) bit periods plus the clamped sample offset.
    function automatic int exp_lat(input int bdr, input int smp);
        return (DW + 1) * (bdr + 1) + ((smp > bdr) ? bdr : smp);
    endfunction

    int g0, f0, o0, v0;
    task automatic snap();
        g0 = got_q.size();
        f0 = frm_n;
        o0 = ovf_n;
        v0 = vld_cyc;
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (int'(cfg_bdr) + 1) @(posedge clk);
        #1;
    endtask

    // One frame followed by three idle bit periods.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(stop);
        uart_rxd = 1'b1;
        repeat (3 * (int'(cfg_bdr) + 1) + 4) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy_rise(input string tag);
        int n;
        n = 0;
        while (!busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, busy, 1);
    endtask

    // Good frame: one word, one-cycle valid, exact latency, no error pulses.
    task automatic check_good(input string tag, input logic [7:0] d);
        check({tag, "_nword"}, got_q.size() - g0, 1);
        if (got_q.size() > g0) check({tag, "_dat"}, got_q[got_q.size()-1], d);
        check({tag, "_vldlen"}, vld_cyc - v0, 1);
        check({tag, "_lat"}, t_vrise - t_brise, exp_lat(int'(cfg_bdr), int'(cfg_smp)));
        check({tag, "_frm"}, frm_n - f0, 0);
        check({tag, "_ovf"}, ovf_n - o0, 0);
    endtask

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        int         t0, g1, o1;

        rst      = 1'b1;
        uart_rxd = 1'b1;
        str_rdy  = 1'b1;
        cfg_bdr  = 8'd3;
        cfg_smp  = 8'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", str_vld, 0);
        check("rst_dat", str_dat, 0);
        check("rst_frm", err_frm, 0);
        check("rst_ovf", err_ovf, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Basic frame.
        snap();
        send_frame(8'hA5, 1'b1);
        check_good("basic", 8'hA5);

        // Start glitch: one clock low.
        snap();
        t0 = cyc;
        uart_rxd = 1'b0;
        @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_seen", (t_brise > t0) ? 1 : 0, 1);
        check("glitch_busylen", t_bfall - t_brise, 1);
        check("glitch_nword", got_q.size() - g0, 0);
        check("glitch_frm", frm_n - f0, 0);

        // Framing error, then a valid frame.
        snap();
        send_frame(8'h3C, 1'b0);
        check("frm_pulse", frm_n - f0, 1);
        check("frm_nword", got_q.size() - g0, 0);
        check("frm_vld", vld_cyc - v0, 0);
        snap();
        send_frame(8'h81, 1'b1);
        check_good("after_frm", 8'h81);

        // Backpressure and overrun.
        str_rdy = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        @(negedge clk);
        check("bp1_vld", str_vld, 1);
        check("bp1_dat", str_dat, 8'h11);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        check("bp2_dat", str_dat, 8'h11);
        check("bp2_ovf", ovf_n - o0, 1);
        check("bp2_frm", frm_n - f0, 0);
        @(posedge clk);
        #1;
        o1 = ovf_n;
        g1 = got_q.size();
        fork
            send_frame(8'h33, 1'b1);
            begin
                wait_busy_rise("bp3_busy");
                repeat (exp_lat(int'(cfg_bdr), int'(cfg_smp)) - 1) @(posedge clk);
                #1;
                str_rdy = 1'b1;
            end
        join
        @(negedge clk);
        check("bp3_ovf", ovf_n - o1, 0);
        check("bp3_nword", got_q.size() - g1, 2);
        if (got_q.size() >= g1 + 2) begin
            check("bp3_pop_old", got_q[g1], 8'h11);
            check("bp3_pop_new", got_q[g1+1], 8'h33);
        end
        check("bp3_vld_clr", str_vld, 0);

        // Sample clamp and baud extremes.
        cfg_bdr = 8'd0;
        cfg_smp = 8'd5;
        snap();
        send_frame(8'h5A, 1'b1);
        check_good("bdr0", 8'h5A);
        cfg_bdr = 8'd255;
        cfg_smp = 8'd128;
        snap();
        send_frame(8'hFF, 1'b1);
        check_good("bdr255", 8'hFF);

        // Reset in the middle of data bit 4, held until the frame has passed.
        cfg_bdr = 8'd3;
        cfg_smp = 8'd1;
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_busy_rise("mid_busy");
                repeat (20) @(posedge clk);
                #1;
                check("mid_pre_busy", busy, 1);
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("mid_rst_busy", busy, 0);
                check("mid_rst_vld", str_vld, 0);
            end
        join
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        snap();
        send_frame(8'h0F, 1'b1);
        check_good("post_rst", 8'h0F);

        // Randomized frames with random timing and occasional bad stop bits.
        for (int k = 0; k < 20; k++) begin
            cfg_bdr = 8'($urandom_range(0, 9));
            cfg_smp = 8'($urandom_range(0, 12));
            d       = 8'($urandom);
            stop    = ($urandom_range(0, 5) != 0);
            snap();
            send_frame(d, stop);
            if (stop) begin
                check_good("rnd", d);
            end else begin
                check("rnd_frm", frm_n - f0, 1);
                check("rnd_nword", got_q.size() - g0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
